pulse_generator: RTL and testbench

PULSE_GENERATOR -- requirements
Module: pulse_generator

---
 rtl/pulse_gen_pkg.sv | 20 ++
 rtl/pulse_phase_counter.sv | 32 +++
 rtl/pulse_generator.sv | 164 ++++++++++++++++
 tb/tb_pulse_generator.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// rtl/pulse_gen_pkg.sv - shared state enum, parameter defaults and phase-length saturation for pulse_generator
package pulse_gen_pkg;

    localparam int N_CH_DEFAULT = 20;
    localparam int TW_DEFAULT   = 16;
    localparam int CW_DEFAULT   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HIGH   = 2'd1,
        ST_LOW    = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    // A zero-length phase would stall the burst, so it is stretched to one clock.
    function automatic logic [31:0] phase_len(input logic [31:0] ticks);
        return (ticks == 32'd0) ? 32'd1 : ticks;
    endfunction

endpackage

// File: rtl/pulse_phase_counter.sv
// rtl/pulse_phase_counter.sv - loadable down-counter timing one HIGH or LOW phase
module pulse_phase_counter #(
    parameter int TW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    output logic          tc_o
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_generator.sv
// rtl/pulse_generator.sv - burst pulse generator for GPIO loopback; PULSE_GEN_WALK_EN selects walking-one channel mode
module pulse_generator
    import pulse_gen_pkg::*;
#(
    parameter int N_CH = N_CH_DEFAULT,
    parameter int TW   = TW_DEFAULT,
    parameter int CW   = CW_DEFAULT
) (
    input  logic            CLOCK_50MHZ,
    input  logic            RESET,
    input  logic            START,
    input  logic            STOP,
    input  logic [TW-1:0]   HIGH_TICKS,
    input  logic [TW-1:0]   LOW_TICKS,
    input  logic [CW-1:0]   PULSE_COUNT,
    input  logic [N_CH-1:0] CH_MASK,
    output logic [N_CH-1:0] GPIO_OUT,
    output logic            BUSY,
    output logic            DONE,
    output logic [CW-1:0]   PULSE_IDX
);

    state_e          state_q, state_d;
    logic [TW-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_CH-1:0] mask_q, mask_d;
    logic [N_CH-1:0] gpio_q, gpio_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [CW-1:0]   idx_q, idx_d;

    logic            tc;
    logic            ld;
    logic [TW-1:0]   ld_val;
    logic            start_ok;
    logic [CW-1:0]   idx_inc;
    logic            last_pulse;
    logic [N_CH-1:0] pat_start;
    logic [N_CH-1:0] pat_next;

    assign start_ok   = START & ~STOP;
    assign idx_inc    = idx_q + 1'b1;
    assign last_pulse = (cnt_q != '0) && (idx_inc == cnt_q);

`ifdef PULSE_GEN_WALK_EN
    logic [N_CH-1:0] walk_one;
    assign walk_one  = {{(N_CH-1){1'b0}}, 1'b1};
    assign pat_start = CH_MASK & walk_one;
    assign pat_next  = mask_q & (walk_one << (int'(idx_inc) % N_CH));
`else
    assign pat_start = CH_MASK;
    assign pat_next  = mask_q;
`endif

    pulse_phase_counter #(.TW(TW)) u_phase_cnt (
        .clk_i      (CLOCK_50MHZ),
        .rst_i      (RESET),
        .load_i     (ld),
        .load_val_i (ld_val),
        .tc_o       (tc)
    );

    always_ff @(posedge CLOCK_50MHZ or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            gpio_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            gpio_q  <= gpio_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
        end
    end

    // Counter is loaded with length-1 so that tc marks the last clock of a phase.
    always_comb begin
        state_d = state_q;
        ld      = 1'b0;
        ld_val  = '0;
        case (state_q)
            ST_IDLE: if (start_ok) begin
                state_d = ST_HIGH;
                ld      = 1'b1;
                ld_val  = TW'(phase_len(32'(HIGH_TICKS)) - 32'd1);
            end
            ST_HIGH: if (STOP) state_d = ST_IDLE;
                else if (tc) begin
                    state_d = ST_LOW;
                    ld      = 1'b1;
                    ld_val  = TW'(phase_len(32'(lo_q)) - 32'd1);
                end
            ST_LOW: if (STOP) state_d = ST_IDLE;
                else if (tc) begin
                    if (last_pulse) state_d = ST_FINISH;
                    else begin
                        state_d = ST_HIGH;
                        ld      = 1'b1;
                        ld_val  = TW'(phase_len(32'(hi_q)) - 32'd1);
                    end
                end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        cnt_d  = cnt_q;
        mask_d = mask_q;
        gpio_d = gpio_q;
        busy_d = busy_q;
        done_d = 1'b0;
        idx_d  = idx_q;
        case (state_q)
            ST_IDLE: if (start_ok) begin
                hi_d   = HIGH_TICKS;
                lo_d   = LOW_TICKS;
                cnt_d  = PULSE_COUNT;
                mask_d = CH_MASK;
                idx_d  = '0;
                busy_d = 1'b1;
                gpio_d = pat_start;
            end
            ST_HIGH: if (STOP) begin
                    gpio_d = '0;
                    busy_d = 1'b0;
                end else if (tc) gpio_d = '0;
            ST_LOW: if (STOP) begin
                    gpio_d = '0;
                    busy_d = 1'b0;
                end else if (tc) begin
                    idx_d = idx_inc;
                    if (last_pulse) begin
                        gpio_d = '0;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else gpio_d = pat_next;
                end
            default: begin
                gpio_d = '0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign GPIO_OUT  = gpio_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PULSE_IDX = idx_q;

endmodule

// File: tb/tb_pulse_generator.sv
// tb/tb_pulse_generator.sv - scoreboard bench for pulse_generator (define PULSE_GEN_WALK_EN for walking-one build)
module tb_pulse_generator;

    localparam logic [19:0] ALL = 20'hFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] hi = '0;
    logic [15:0] lo = '0;
    logic [7:0]  cnt = '0;
    logic [19:0] mask = '0;
    logic [19:0] gpio;
    logic        busy;
    logic        done;
    logic [7:0]  idx;

    typedef struct packed {
        logic [19:0] gpio;
        logic        busy;
        logic        done;
        logic [7:0]  idx;
        logic [7:0]  tid;
        logic [15:0] seq;
    } rec_t;

    rec_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   seq_n = 0;
    logic [7:0] cur_tid = '0;

    pulse_generator #(.N_CH(20), .TW(16), .CW(8)) dut (
        .CLOCK_50MHZ (clk),
        .RESET       (rst),
        .START       (start),
        .STOP        (stop),
        .HIGH_TICKS  (hi),
        .LOW_TICKS   (lo),
        .PULSE_COUNT (cnt),
        .CH_MASK     (mask),
        .GPIO_OUT    (gpio),
        .BUSY        (busy),
        .DONE        (done),
        .PULSE_IDX   (idx)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] exp_hi(input logic [19:0] m, input int p);
`ifdef PULSE_GEN_WALK_EN
        logic [19:0] one;
        one = 20'd1;
        return m & (one << (p % 20));
`else
        return (p >= 0) ? m : 20'd0;
`endif
    endfunction

    always @(negedge clk) begin
        rec_t r;
        if (sb.size() != 0) begin
            r = sb.pop_front();
            total++;
            if (gpio !== r.gpio || busy !== r.busy || done !== r.done || idx !== r.idx) begin
                bad++;
                $display("FAIL burst t%0d #%0d: got gpio=%h busy=%b done=%b idx=%0d want gpio=%h busy=%b done=%b idx=%0d",
                         r.tid, r.seq, gpio, busy, done, idx, r.gpio, r.busy, r.done, r.idx);
            end
        end
    end

    task automatic push(input logic [19:0] g, input logic b, input logic d, input int p, input int n);
        rec_t r;
        for (int i = 0; i < n; i++) begin
            r.gpio = g; r.busy = b; r.done = d; r.idx = 8'(p);
            r.tid = cur_tid; r.seq = 16'(seq_n);
            seq_n++;
            sb.push_back(r);
        end
    endtask

    task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic start_burst(input logic [15:0] h, input logic [15:0] l, input logic [7:0] c, input logic [19:0] m);
        @(posedge clk); #1;
        start = 1'b1; hi = h; lo = l; cnt = c; mask = m;
        @(posedge clk); #1;
        start = 1'b0;
        seq_n = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain t%0d: got %0d pending want 0", cur_tid, sb.size());
            sb.delete();
        end
    endtask

    // Continuous burst of np full pulses, then STOP lands in the first cycle of pulse np.
    task automatic cont_stop(input logic [15:0] h, input logic [15:0] l, input logic [19:0] m,
                             input int hc, input int lc, input int np);
        int mcyc;
        start_burst(h, l, 8'd0, m);
        for (int p = 0; p < np; p++) begin
            push(exp_hi(m, p), 1'b1, 1'b0, p, hc);
            push(20'd0, 1'b1, 1'b0, p, lc);
        end
        push(exp_hi(m, np), 1'b1, 1'b0, np, 1);
        mcyc = np * (hc + lc) + 1;
        repeat (mcyc - 1) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        push(20'd0, 1'b0, 1'b0, np, 3);
        drain();
    endtask

    initial begin
        #12;
        check_now("reset_gpio", 32'(gpio), 32'd0);
        check_now("reset_busy", 32'(busy), 32'd0);
        check_now("reset_done", 32'(done), 32'd0);
        check_now("reset_idx",  32'(idx),  32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // 3/2 ticks, two pulses, all channels
        cur_tid = 8'd1;
        start_burst(16'd3, 16'd2, 8'd2, ALL);
        push(exp_hi(ALL, 0), 1'b1, 1'b0, 0, 3);
        push(20'd0,          1'b1, 1'b0, 0, 2);
        push(exp_hi(ALL, 1), 1'b1, 1'b0, 1, 3);
        push(20'd0,          1'b1, 1'b0, 1, 2);
        push(20'd0,          1'b0, 1'b1, 2, 1);
        push(20'd0,          1'b0, 1'b0, 2, 2);
        drain();

        // zero-length phases saturate to one clock
        cur_tid = 8'd2;
        start_burst(16'd0, 16'd0, 8'd1, 20'h00A5A);
        push(exp_hi(20'h00A5A, 0), 1'b1, 1'b0, 0, 1);
        push(20'd0,                1'b1, 1'b0, 0, 1);
        push(20'd0,                1'b0, 1'b1, 1, 1);
        push(20'd0,                1'b0, 1'b0, 1, 2);
        drain();

        cur_tid = 8'd3;
        cont_stop(16'd2, 16'd1, 20'h0F0F0, 2, 1, 5);

        // START with STOP in IDLE is ignored; idx holds 5
        cur_tid = 8'd4;
        @(posedge clk); #1 start = 1'b1; stop = 1'b1;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        seq_n = 0;
        push(20'd0, 1'b0, 1'b0, 5, 3);
        drain();

        // START held into HIGH and inputs changed mid-burst
        cur_tid = 8'd5;
        @(posedge clk); #1;
        start = 1'b1; hi = 16'd2; lo = 16'd1; cnt = 8'd1; mask = ALL;
        @(posedge clk); #1;
        hi = 16'd7; lo = 16'd5; cnt = 8'd3; mask = 20'd0;
        seq_n = 0;
        push(exp_hi(ALL, 0), 1'b1, 1'b0, 0, 2);
        push(20'd0,          1'b1, 1'b0, 0, 1);
        push(20'd0,          1'b0, 1'b1, 1, 1);
        push(20'd0,          1'b0, 1'b0, 1, 2);
        @(posedge clk); #1 start = 1'b0;
        drain();

        // asynchronous reset in the middle of HIGH
        cur_tid = 8'd6;
        start_burst(16'd4, 16'd1, 8'd1, ALL);
        push(exp_hi(ALL, 0), 1'b1, 1'b0, 0, 2);
        @(posedge clk); #6;
        rst = 1'b1;
        #1;
        check_now("async_rst_gpio", 32'(gpio), 32'd0);
        check_now("async_rst_busy", 32'(busy), 32'd0);
        check_now("async_rst_idx",  32'(idx),  32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drain();
        start_burst(16'd4, 16'd1, 8'd1, ALL);
        push(exp_hi(ALL, 0), 1'b1, 1'b0, 0, 4);
        push(20'd0,          1'b1, 1'b0, 0, 1);
        push(20'd0,          1'b0, 1'b1, 1, 1);
        push(20'd0,          1'b0, 1'b0, 1, 2);
        drain();

        // continuous mode: index wraps 255 -> 0 and burst keeps going
        cur_tid = 8'd7;
        cont_stop(16'd0, 16'd0, 20'h80001, 1, 1, 257);

`ifdef PULSE_GEN_WALK_EN
        cur_tid = 8'd8;
        start_burst(16'd1, 16'd1, 8'd22, ALL);
        for (int p = 0; p < 22; p++) begin
            push(20'd1 << (p % 20), 1'b1, 1'b0, p, 1);
            push(20'd0,             1'b1, 1'b0, p, 1);
        end
        push(20'd0, 1'b0, 1'b1, 22, 1);
        push(20'd0, 1'b0, 1'b0, 22, 2);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
